neuron_layer_1h: RTL

- Time-multiplexed layer of M fixed-point neurons fed by an N-bit one-hot/binary input vector.
- Each weight is either added to the accumulator or skipped, according to its input bit. No multipliers.
- P inputs per neuron are consumed per cycle, and all M neurons run in parallel.
- Adds bias, applies the selected activation, registers the M outputs, and signals completion with a start/ack/done handshake.
- Successor to the single-neuron one-hot block. Used as hidden or output layer in the digit-classifier datapath.

---
 rtl/nn_pkg.sv | 30 +++
 rtl/neuron_1h_lane.sv | 84 ++++++++
 rtl/neuron_layer_1h.sv | 101 ++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and helpers for the one-hot (multiplier-free) neuron layers.
package nn_pkg;

    localparam int ACT_LINEAR = 0;
    localparam int ACT_RELU   = 1;
    localparam int ACT_LEAKY  = 2;

    // Working width for the FIN arithmetic; wide enough for any sane layer.
    localparam int ALIGNW = 64;

    typedef enum logic [1:0] {IDLE, ACCUM, FIN} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Move a fixed-point value from from_fr to to_fr fraction bits (floor on right shift).
    function automatic logic signed [ALIGNW-1:0] align_shift(
        input logic signed [ALIGNW-1:0] v,
        input int                       from_fr,
        input int                       to_fr
    );
        if (to_fr >= from_fr) return v <<< (to_fr - from_fr);
        return v >>> (from_fr - to_fr);
    endfunction

endpackage

// File: rtl/neuron_1h_lane.sv
// One neuron of the layer: gated-add accumulator, bias/rescale/activation and output register.
// Define NEURON_LAYER_1H_SAT_EN to saturate (instead of wrap) when reducing to WIDTH.
module neuron_1h_lane
    import nn_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int N          = 16,
    parameter int P          = 4,
    parameter int WFR        = 6,
    parameter int BFR        = 5,
    parameter int OFR        = 6,
    parameter int ACT        = 2,
    parameter int LEAK_SHIFT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               acc_en,
    input  logic               fin,
    input  logic [P-1:0]       xbits,
    input  logic [P*WIDTH-1:0] wchunk,
    input  logic [WIDTH-1:0]   bias,
    output logic [WIDTH-1:0]   out
);

    localparam int ACCW = WIDTH + clog2(N + 1) + 1;

    logic signed [ACCW-1:0]   acc;
    logic signed [ACCW-1:0]   chunk_sum;
    logic        [WIDTH-1:0]  wj;
    logic signed [ALIGNW-1:0] acc_w;
    logic signed [ALIGNW-1:0] bias_w;
    logic signed [ALIGNW-1:0] s;
    logic signed [ALIGNW-1:0] act_v;
    logic        [WIDTH-1:0]  res;

    always_comb begin
        chunk_sum = '0;
        wj        = '0;
        for (int j = 0; j < P; j++) begin
            wj = wchunk[j*WIDTH +: WIDTH];
            if (xbits[j]) chunk_sum = chunk_sum + {{(ACCW-WIDTH){wj[WIDTH-1]}}, wj};
        end
    end

    always_comb begin
        acc_w  = {{(ALIGNW-ACCW){acc[ACCW-1]}}, acc};
        bias_w = align_shift({{(ALIGNW-WIDTH){bias[WIDTH-1]}}, bias}, BFR, WFR);
        s      = align_shift(acc_w + bias_w, WFR, OFR);
        if (ACT == ACT_RELU) begin
            act_v = (s > 0) ? s : '0;
        end else if (ACT == ACT_LEAKY) begin
            act_v = (s > 0) ? s : (s >>> LEAK_SHIFT);
        end else begin
            act_v = s;
        end
`ifdef NEURON_LAYER_1H_SAT_EN
        if (act_v > ((64'sd1 <<< (WIDTH - 1)) - 64'sd1)) begin
            res = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (act_v < -(64'sd1 <<< (WIDTH - 1))) begin
            res = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            res = WIDTH'(act_v);
        end
`else
        res = WIDTH'(act_v);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            out <= '0;
        end else begin
            if (clr) begin
                acc <= '0;
            end else if (acc_en) begin
                acc <= acc + chunk_sum;
            end
            if (fin) out <= res;
        end
    end

endmodule

// File: rtl/neuron_layer_1h.sv
// Time-multiplexed layer of M one-hot-input neurons with start/ack/done handshake.
// Optional macro NEURON_LAYER_1H_SAT_EN selects saturating output reduction (see lane).
module neuron_layer_1h
    import nn_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int N          = 16,
    parameter int M          = 4,
    parameter int P          = 4,
    parameter int WFR        = 6,
    parameter int BFR        = 5,
    parameter int OFR        = 6,
    parameter int ACT        = 2,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N-1:0]           X,
    input  logic [M*N*WIDTH-1:0]   W,
    input  logic [M*WIDTH-1:0]     b,
    output logic [M*WIDTH-1:0]     out,
    output logic                   done,
    output logic                   ack,
    output logic                   busy
);

    localparam int CHUNKS = N / P;
    localparam int CNTW   = (CHUNKS > 1) ? clog2(CHUNKS) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(CHUNKS - 1);

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic [N-1:0]    x_local;
    logic            clr;
    logic            acc_en;
    logic            fin;

    assign clr    = (state == IDLE) && start;
    assign acc_en = (state == ACCUM);
    assign fin    = (state == FIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            x_local <= '0;
            ack     <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ack  <= 1'b0;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        x_local <= X;
                        cnt     <= '0;
                        ack     <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= FIN;
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar m = 0; m < M; m++) begin : g_lane
        neuron_1h_lane #(
            .WIDTH      (WIDTH),
            .N          (N),
            .P          (P),
            .WFR        (WFR),
            .BFR        (BFR),
            .OFR        (OFR),
            .ACT        (ACT),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .acc_en (acc_en),
            .fin    (fin),
            .xbits  (x_local[cnt*P +: P]),
            .wchunk (W[(m*N + cnt*P)*WIDTH +: P*WIDTH]),
            .bias   (b[m*WIDTH +: WIDTH]),
            .out    (out[m*WIDTH +: WIDTH])
        );
    end

endmodule
